// File: rtl/gate_vector_checker_pkg.sv
// Shared definitions for the gate vector checker: FSM state encodings,
// truth-table constants for common 2-input gates and the hold counter width.
package gate_vector_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit index of each truth table is the vector {i0,i1}.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

    localparam int CNT_W = 8;

endpackage

// File: rtl/gate_vector_checker_hold_counter.sv
// Per-vector hold timer: counts cycles while enabled and flags the cycle whose
// closing edge is the sample point for the current vector.
module hold_counter
    import gate_vector_checker_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign term = en && (cnt == TERM_CNT);

endmodule

// File: rtl/gate_vector_checker.sv
// Drives a 2-input gate through all four input vectors, samples its output at
// the end of each hold window and records mismatches against TRUTH.
//
// state   | meaning
// IDLE    | waiting for start, gate inputs parked at 00
// RUN     | stepping vectors 00,01,10,11, one hold window each
// DONE    | results frozen; start launches a fresh run
module gate_vector_checker
    import gate_vector_checker_pkg::*;
#(
    parameter int         HOLD_CYCLES = 4,
    parameter logic [3:0] TRUTH       = TT_AND
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y_in,
    output logic       i0,
    output logic       i1,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic       first_fail_valid,
    output logic [1:0] first_fail_vec
);

    state_t     state;
    logic [1:0] vec;
    logic       term;
    logic       mismatch;
    logic [2:0] err_next;

    // Counter is held clear outside RUN so every run starts from zero.
    hold_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  ((state != ST_RUN) || term),
        .en   (state == ST_RUN),
        .term (term)
    );

    assign mismatch = (y_in != TRUTH[vec]);
    assign err_next = err_count + {2'b00, mismatch};
    assign pass     = done && (err_count == 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            vec              <= 2'd0;
            i0               <= 1'b0;
            i1               <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_count        <= 3'd0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 2'd0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state            <= ST_RUN;
                        vec              <= 2'd0;
                        i0               <= 1'b0;
                        i1               <= 1'b0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        err_count        <= 3'd0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= 2'd0;
                    end
                end
                ST_RUN: begin
                    if (term) begin
                        err_count <= err_next;
                        if (mismatch && !first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= vec;
                        end
                        if (vec == 2'd3) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            i0    <= 1'b0;
                            i1    <= 1'b0;
                        end else begin
                            vec        <= vec + 2'd1;
                            {i0, i1}   <= vec + 2'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench: three checker instances (AND/hold 4, OR/hold 4, AND/hold 2)
// each wrapped around a modelled AND gate, with a forceable y on instance 0.
module tb_gate_vector_checker;
    import gate_vector_checker_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       y_sel;
    logic       y_force;
    logic       start_v  [3];
    logic       y_v      [3];
    logic       i0_o     [3];
    logic       i1_o     [3];
    logic       busy_o   [3];
    logic       done_o   [3];
    logic       pass_o   [3];
    logic       ffv_o    [3];
    logic [2:0] err_o    [3];
    logic [1:0] ffvec_o  [3];

    int checks = 0;
    int errors = 0;

    assign y_v[0] = y_sel ? y_force : (i0_o[0] & i1_o[0]);
    assign y_v[1] = i0_o[1] & i1_o[1];
    assign y_v[2] = i0_o[2] & i1_o[2];

    gate_vector_checker #(.HOLD_CYCLES(4), .TRUTH(TT_AND)) u_and (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .y_in(y_v[0]),
        .i0(i0_o[0]), .i1(i1_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .err_count(err_o[0]),
        .first_fail_valid(ffv_o[0]), .first_fail_vec(ffvec_o[0]));

    gate_vector_checker #(.HOLD_CYCLES(4), .TRUTH(TT_OR)) u_or (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .y_in(y_v[1]),
        .i0(i0_o[1]), .i1(i1_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .err_count(err_o[1]),
        .first_fail_valid(ffv_o[1]), .first_fail_vec(ffvec_o[1]));

    gate_vector_checker #(.HOLD_CYCLES(2), .TRUTH(TT_AND)) u_h2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .y_in(y_v[2]),
        .i0(i0_o[2]), .i1(i1_o[2]), .busy(busy_o[2]), .done(done_o[2]),
        .pass(pass_o[2]), .err_count(err_o[2]),
        .first_fail_valid(ffv_o[2]), .first_fail_vec(ffvec_o[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input int sel, input string tag);
        check({tag, "_i0"},    i0_o[sel], 0);
        check({tag, "_i1"},    i1_o[sel], 0);
        check({tag, "_busy"},  busy_o[sel], 0);
        check({tag, "_done"},  done_o[sel], 0);
        check({tag, "_pass"},  pass_o[sel], 0);
        check({tag, "_err"},   err_o[sel], 0);
        check({tag, "_ffv"},   ffv_o[sel], 0);
        check({tag, "_ffvec"}, ffvec_o[sel], 0);
    endtask

    // One full run: pulse start, check each vector at the start of its window,
    // measure latency to done and check the final results.
    task automatic run_seq(input int sel, input int hold, input int exp_err,
                           input int exp_ffv, input int exp_ffvec, input bit poke);
        int cyc = 0;
        @(negedge clk) start_v[sel] = 1'b1;
        @(negedge clk) start_v[sel] = 1'b0;
        check("run_busy", busy_o[sel], 1);
        check("run_done_low", done_o[sel], 0);
        while (!done_o[sel] && cyc < 64) begin
            if ((cyc % hold) == 0 && cyc < 4 * hold)
                check("vec", {30'd0, i0_o[sel], i1_o[sel]}, cyc / hold);
            if (poke && cyc == 5) start_v[sel] = 1'b1;
            if (poke && cyc == 6) start_v[sel] = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("done_latency", cyc, 4 * hold);
        check("err_count", err_o[sel], exp_err);
        check("first_fail_valid", ffv_o[sel], exp_ffv);
        check("first_fail_vec", ffvec_o[sel], exp_ffvec);
        check("pass", pass_o[sel], (exp_err == 0) ? 1 : 0);
        check("done_busy", busy_o[sel], 0);
        check("done_i0i1", {30'd0, i0_o[sel], i1_o[sel]}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        y_sel   = 1'b0;
        y_force = 1'b0;
        foreach (start_v[i]) start_v[i] = 1'b0;

        #12;
        check_idle_outputs(0, "reset");
        check("reset_h2_busy", busy_o[2], 0);
        @(negedge clk) rst_n = 1'b1;

        // AND gate against AND table: clean pass
        run_seq(0, 4, 0, 0, 0, 1'b0);
        // AND gate against OR table: vectors 01 and 10 mismatch
        run_seq(1, 4, 2, 1, 1, 1'b0);
        // y stuck at 1 against AND table: vectors 00,01,10 mismatch
        y_sel   = 1'b1;
        y_force = 1'b1;
        run_seq(0, 4, 3, 1, 0, 1'b0);

        // reset during vector 10 with errors already recorded
        @(negedge clk) start_v[0] = 1'b1;
        @(negedge clk) start_v[0] = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset_vec", {30'd0, i0_o[0], i1_o[0]}, 2);
        check("pre_reset_err", err_o[0], 2);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs(0, "midrun_reset");
        y_sel = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        run_seq(0, 4, 0, 0, 0, 1'b0);

        // start during RUN ignored, then restart from DONE
        run_seq(0, 4, 0, 0, 0, 1'b1);
        run_seq(0, 4, 0, 0, 0, 1'b0);

        // hold 2 with start held high: 8 RUN cycles + 1 DONE cycle per run
        @(negedge clk) start_v[2] = 1'b1;
        for (int cyc = 0; cyc < 27; cyc++) begin
            @(negedge clk);
            check("b2b_done", done_o[2], ((cyc % 9) == 8) ? 1 : 0);
            check("b2b_busy", busy_o[2], ((cyc % 9) == 8) ? 0 : 1);
            if ((cyc % 9) == 8) check("b2b_pass", pass_o[2], 1);
        end
        start_v[2] = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
